snake_direction_queue: RTL and testbench

Upstream stage of the snake game core: turns the four raw push-buttons into the one-hot movement direction the game logic consumes on every update step. It synchronises and debounces each button and detects presses. It rejects reversals and repeats, and buffers up to two pending turns so that quick double-taps between update steps are not lost. The game core sees a direction register that changes only on the update strobe.

---
 rtl/snake_direction_queue.sv | 138 +++++++++++++
 tb/tb_snake_direction_queue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_direction_queue.sv
// rtl/snake_direction_queue.sv - button debounce, turn filter and two-deep direction queue
module snake_direction_queue #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       tick,
  output logic [3:0] direction,
  output logic [1:0] level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Button bit order matches the one-hot direction code: left, right, up, down.
  logic [3:0]         btn_raw;
  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0]         stable_q, stable_d;
  logic [3:0]         press_q, press_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;

  logic [3:0] direction_q, direction_d;
  logic [3:0] head_q, head_d;
  logic [3:0] tail_q, tail_d;
  logic [1:0] level_q, level_d;

  logic [3:0] req;
  logic [3:0] ref_dir;
  logic [3:0] ref_opp;
  logic       accept;
  logic       pop;
  logic       push;

  assign btn_raw = {down, up, right, left};

  // Two-flop synchroniser, per-button debounce counter and rising-edge press pulse.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = '0;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = ~stable_q[i];
        press_d[i]  = ~stable_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Pick one request, filter repeats and reversals against the newest pending heading.
  always_comb begin
    req = 4'b0000;
    if (press_q[2])      req = 4'b0100;
    else if (press_q[3]) req = 4'b1000;
    else if (press_q[0]) req = 4'b0001;
    else if (press_q[1]) req = 4'b0010;

    if (level_q == 2'd2)      ref_dir = tail_q;
    else if (level_q == 2'd1) ref_dir = head_q;
    else                      ref_dir = direction_q;

    ref_opp = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};
    accept  = (req != 4'b0000) &&
              ((ref_dir == 4'b0000) || ((req != ref_dir) && (req != ref_opp)));
    pop     = tick && (level_q != 2'd0);
    push    = accept && ((level_q != 2'd2) || pop);
  end

  // Queue update: tick pops the head into the direction register, accepted turns go to the tail.
  always_comb begin
    direction_d = pop ? head_q : direction_q;
    head_d      = head_q;
    tail_d      = tail_q;
    level_d     = level_q;
    case ({pop, push})
      2'b10: begin
        head_d  = tail_q;
        tail_d  = 4'b0000;
        level_d = level_q - 2'd1;
      end
      2'b01: begin
        if (level_q == 2'd0) head_d = req;
        else                 tail_d = req;
        level_d = level_q + 2'd1;
      end
      2'b11: begin
        if (level_q == 2'd1) begin
          head_d = req;
        end else begin
          head_d = tail_q;
          tail_d = req;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset (game over) stops the snake and flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      press_q     <= '0;
      cnt_q       <= '0;
      direction_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      level_q     <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
      direction_q <= direction_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      level_q     <= level_d;
    end
  end

  assign direction = direction_q;
  assign level     = level_q;

endmodule

// File: tb/tb_snake_direction_queue.sv
// tb/tb_snake_direction_queue.sv - randomized and directed bench for snake_direction_queue
`timescale 1ns/100ps
module tb_snake_direction_queue;

  localparam int D = 4;
  localparam logic [3:0] L = 4'b0001;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] U = 4'b0100;
  localparam logic [3:0] DN = 4'b1000;
  localparam logic [3:0] NONE = 4'b0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       left, right, up, down, tick;
  logic [3:0] direction;
  logic [1:0] level;

  int vectors;
  int fails;

  logic [3:0] m_dir;
  logic [3:0] m_press;
  logic [3:0] m_stable;
  logic [3:0] m_q[$];
  logic [3:0] raw_hist[$];
  logic [3:0] seen_hist[$];

  snake_direction_queue #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .up(up), .down(down),
    .tick(tick), .direction(direction), .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      L:  return R;
      R:  return L;
      U:  return DN;
      DN: return U;
      default: return NONE;
    endcase
  endfunction

  task automatic model_reset();
    m_dir = NONE;
    m_press = NONE;
    m_stable = NONE;
    m_q.delete();
    raw_hist.delete();
    seen_hist.delete();
  endtask

  // Behaviour of one rising edge, evaluated from the inputs about to be sampled.
  task automatic model_edge();
    logic [3:0] req, refd, raw, seen, np;
    logic acc, pop, push, all_dis;
    if (rst) begin
      model_reset();
    end else begin
      if (m_press[2])      req = U;
      else if (m_press[3]) req = DN;
      else if (m_press[0]) req = L;
      else if (m_press[1]) req = R;
      else                 req = NONE;
      refd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
      acc  = (req != NONE) && (refd == NONE || (req != refd && req != opposite(refd)));
      pop  = tick && (m_q.size() > 0);
      push = acc && (m_q.size() < 2 || pop);
      if (pop) m_dir = m_q.pop_front();
      if (push) m_q.push_back(req);
      // the debouncer sees the raw level from two edges earlier
      raw  = {down, up, right, left};
      seen = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : NONE;
      raw_hist.push_back(raw);
      if (raw_hist.size() > 4) void'(raw_hist.pop_front());
      seen_hist.push_back(seen);
      if (seen_hist.size() > D) void'(seen_hist.pop_front());
      np = NONE;
      for (int b = 0; b < 4; b++) begin
        if (seen_hist.size() == D) begin
          all_dis = 1'b1;
          for (int k = 0; k < D; k++)
            if (seen_hist[k][b] == m_stable[b]) all_dis = 1'b0;
          if (all_dis) begin
            np[b] = ~m_stable[b];
            m_stable[b] = ~m_stable[b];
          end
        end
      end
      m_press = np;
    end
  endtask

  task automatic apply(input logic [3:0] b, input logic tk, input int n);
    logic [1:0] exp_l;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {down, up, right, left} = b;
      tick = tk;
      model_edge();
      @(posedge clk);
      #1;
      tick = 1'b0;
      exp_l = 2'(m_q.size());
      vectors++;
      if (direction !== m_dir || level !== exp_l) begin
        fails++;
        $display("FAIL model_step t=%0t: direction=%b level=%0d expected direction=%b level=%0d",
                 $time, direction, level, m_dir, exp_l);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (direction !== NONE || level !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: direction=%b level=%0d expected 0000 0", direction, level);
    end
    apply(U, 1'b0, 1);
    rst = 1'b0;
    apply(U, 1'b0, 6);
    vectors++;
    if (level !== 2'd0) begin
      fails++;
      $display("FAIL press_latency_early: level=%0d expected 0 at edge 6", level);
    end
    apply(U, 1'b0, 1);
    vectors++;
    if (level !== 2'd1) begin
      fails++;
      $display("FAIL press_latency: level=%0d expected 1 at edge 7", level);
    end
    apply(U, 1'b0, 3);
    apply(NONE, 1'b0, 8);
    apply(NONE, 1'b1, 1);
    vectors++;
    if (direction !== U || level !== 2'd0) begin
      fails++;
      $display("FAIL first_tick: direction=%b level=%0d expected 0100 0", direction, level);
    end
  endtask

  task automatic test_reversal();
    apply(R, 1'b0, 8); apply(NONE, 1'b0, 8); apply(NONE, 1'b1, 1);
    vectors++;
    if (direction !== R) begin
      fails++;
      $display("FAIL turn_right: direction=%b expected 0010", direction);
    end
    apply(L, 1'b0, 8); apply(NONE, 1'b0, 8);
    apply(R, 1'b0, 8); apply(NONE, 1'b0, 8);
    vectors++;
    if (direction !== R || level !== 2'd0) begin
      fails++;
      $display("FAIL reject_reverse_repeat: direction=%b level=%0d expected 0010 0", direction, level);
    end
    apply(U, 1'b0, 8);
    vectors++;
    if (level !== 2'd1) begin
      fails++;
      $display("FAIL accept_perpendicular: level=%0d expected 1", level);
    end
    apply(NONE, 1'b0, 8); apply(NONE, 1'b1, 1);
  endtask

  task automatic test_two_deep();
    apply(L, 1'b0, 8); apply(NONE, 1'b0, 8); apply(NONE, 1'b1, 1);
    apply(U, 1'b0, 8); apply(NONE, 1'b0, 8);
    apply(R, 1'b0, 8); apply(NONE, 1'b0, 8);
    apply(DN, 1'b0, 8); apply(NONE, 1'b0, 8);
    vectors++;
    if (level !== 2'd2 || direction !== L) begin
      fails++;
      $display("FAIL queue_full: direction=%b level=%0d expected 0001 2", direction, level);
    end
    apply(NONE, 1'b1, 1);
    vectors++;
    if (direction !== U || level !== 2'd1) begin
      fails++;
      $display("FAIL pop_first: direction=%b level=%0d expected 0100 1", direction, level);
    end
    apply(NONE, 1'b0, 1); apply(NONE, 1'b1, 1);
    vectors++;
    if (direction !== R || level !== 2'd0) begin
      fails++;
      $display("FAIL pop_second: direction=%b level=%0d expected 0010 0", direction, level);
    end
  endtask

  task automatic test_back_to_back();
    apply(U, 1'b0, 8); apply(NONE, 1'b0, 8);
    apply(L, 1'b0, 8); apply(NONE, 1'b0, 8);
    apply(DN, 1'b0, 6); apply(DN, 1'b1, 1);
    vectors++;
    if (direction !== U || level !== 2'd2) begin
      fails++;
      $display("FAIL push_pop_full: direction=%b level=%0d expected 0100 2", direction, level);
    end
    apply(DN, 1'b0, 1); apply(NONE, 1'b0, 8); apply(NONE, 1'b1, 1);
    vectors++;
    if (direction !== L) begin
      fails++;
      $display("FAIL push_pop_next: direction=%b expected 0001", direction);
    end
    apply(NONE, 1'b0, 1); apply(NONE, 1'b1, 1);
    vectors++;
    if (direction !== DN || level !== 2'd0) begin
      fails++;
      $display("FAIL push_pop_tail: direction=%b level=%0d expected 1000 0", direction, level);
    end
  endtask

  task automatic test_bounce_priority();
    for (int i = 0; i < 6; i++) begin
      apply(L, 1'b0, 2); apply(NONE, 1'b0, 1);
    end
    apply(NONE, 1'b0, 8);
    vectors++;
    if (level !== 2'd0) begin
      fails++;
      $display("FAIL bounce: level=%0d expected 0", level);
    end
    rst = 1'b1;
    apply(NONE, 1'b0, 1);
    rst = 1'b0;
    apply(U | L, 1'b0, 8);
    vectors++;
    if (level !== 2'd1) begin
      fails++;
      $display("FAIL priority_level: level=%0d expected 1", level);
    end
    apply(NONE, 1'b0, 8); apply(NONE, 1'b1, 1);
    vectors++;
    if (direction !== U || level !== 2'd0) begin
      fails++;
      $display("FAIL priority_dir: direction=%b level=%0d expected 0100 0", direction, level);
    end
    apply(NONE, 1'b0, 1); apply(NONE, 1'b1, 1);
    vectors++;
    if (direction !== U) begin
      fails++;
      $display("FAIL empty_tick_hold: direction=%b expected 0100", direction);
    end
  endtask

  task automatic test_async_reset();
    apply(L, 1'b0, 8); apply(NONE, 1'b0, 8);
    apply(DN, 1'b0, 8); apply(NONE, 1'b0, 8);
    apply(R, 1'b0, 4);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (direction !== NONE || level !== 2'd0) begin
      fails++;
      $display("FAIL async_reset: direction=%b level=%0d expected 0000 0", direction, level);
    end
    rst = 1'b0;
    apply(R, 1'b0, 6);
    vectors++;
    if (level !== 2'd0) begin
      fails++;
      $display("FAIL rearm_early: level=%0d expected 0", level);
    end
    apply(R, 1'b0, 1);
    vectors++;
    if (level !== 2'd1) begin
      fails++;
      $display("FAIL rearm_latency: level=%0d expected 1", level);
    end
    apply(NONE, 1'b0, 8);
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic       last_tk;
    logic       tk;
    int         hold;
    last_tk = 1'b0;
    for (int g = 0; g < 120; g++) begin
      b = 4'($urandom % 16);
      if ($urandom % 3 == 0) b = NONE;
      hold = $urandom_range(1, 12);
      for (int i = 0; i < hold; i++) begin
        tk = ($urandom % 5 == 0) && !last_tk;
        apply(b, tk, 1);
        last_tk = tk;
      end
    end
  endtask

  initial begin
    vectors = 0;
    fails = 0;
    rst = 1'b1;
    {down, up, right, left} = NONE;
    tick = 1'b0;
    model_reset();
    test_reset();
    test_reversal();
    test_two_deep();
    test_back_to_back();
    test_bounce_priority();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
